// File: rtl/apb_pcie_mon.sv
// APB-mapped PCIe link / DMA channel monitor: link-event and busy-cycle counters,
// captured config BDF, and a maskable level interrupt.
`timescale 1ns/1ps
module apb_pcie_mon #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_lnk_up,
  input  logic [CH_NUM-1:0] i_dma_busy,
  input  logic              i_cfg_valid,
  input  logic [15:0]       i_cfg_bdf,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [11:0]       i_paddr,
  input  logic [31:0]       i_pwdata,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic              o_irq
);

  localparam int unsigned IRQ_W     = 2 + CH_NUM;
  localparam int unsigned BUSY_BASE = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  localparam logic [9:0] A_STATUS   = 10'h000;
  localparam logic [9:0] A_BDF      = 10'h001;
  localparam logic [9:0] A_IRQ_STAT = 10'h002;
  localparam logic [9:0] A_IRQ_MASK = 10'h003;
  localparam logic [9:0] A_LNKDN    = 10'h004;
  localparam logic [9:0] A_PARAM    = 10'h005;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lnk_d;
  logic [CH_NUM-1:0]      busy_d;
  logic [15:0]            bdf_q;
  logic [IRQ_W-1:0]       irq_stat;
  logic [IRQ_W-1:0]       irq_mask;
  logic [CNT_WIDTH-1:0]   lnkdn_cnt;
  logic [CNT_WIDTH-1:0]   busy_cnt [CH_NUM];

  logic [9:0]        word_c;
  logic              lnk_s_c;
  logic              lnk_rise_c;
  logic              lnk_fall_c;
  logic [CH_NUM-1:0] busy_fall_c;
  logic [IRQ_W-1:0]  irq_set_c;
  logic [31:0]       rd_data_c;
  logic              hit_c;
  logic              ro_c;
  logic [CH_NUM-1:0] busy_sel_c;
  logic              err_c;
  logic              xfer_c;
  logic              wr_c;
  logic              lnk_clr_c;
  logic [CH_NUM-1:0] busy_clr_c;
  logic [IRQ_W-1:0]  w1c_c;
  logic              mask_we_c;
  logic              unused_bits;

  assign unused_bits = ^{i_paddr[1:0], i_pwdata[31:IRQ_W]};

  // Event detection on the synchronised link and per-channel busy falls
  assign word_c      = i_paddr[11:2];
  assign lnk_s_c     = sync_q[SYNC_STAGES-1];
  assign lnk_rise_c  = lnk_s_c & ~lnk_d;
  assign lnk_fall_c  = ~lnk_s_c & lnk_d;
  assign busy_fall_c = busy_d & ~i_dma_busy;
  assign irq_set_c   = {busy_fall_c, lnk_fall_c, lnk_rise_c};

  // Register map decode and read mux
  always_comb begin
    rd_data_c  = '0;
    hit_c      = 1'b0;
    ro_c       = 1'b0;
    busy_sel_c = '0;
    case (word_c)
      A_STATUS:   begin hit_c = 1'b1; ro_c = 1'b1; rd_data_c = 32'({i_dma_busy, 7'd0, lnk_s_c}); end
      A_BDF:      begin hit_c = 1'b1; ro_c = 1'b1; rd_data_c = 32'(bdf_q); end
      A_IRQ_STAT: begin hit_c = 1'b1; rd_data_c = 32'(irq_stat); end
      A_IRQ_MASK: begin hit_c = 1'b1; rd_data_c = 32'(irq_mask); end
      A_LNKDN:    begin hit_c = 1'b1; rd_data_c = 32'(lnkdn_cnt); end
      A_PARAM:    begin hit_c = 1'b1; ro_c = 1'b1; rd_data_c = 32'({6'(CNT_WIDTH), 4'd0, 4'(CH_NUM)}); end
      default:    ;
    endcase
    for (int unsigned n = 0; n < CH_NUM; n++) begin
      if (word_c == 10'(BUSY_BASE + n)) begin
        hit_c         = 1'b1;
        busy_sel_c[n] = 1'b1;
        rd_data_c     = 32'(busy_cnt[n]);
      end
    end
  end

  assign err_c      = ~hit_c | (i_pwrite & ro_c);
  assign xfer_c     = (state == ST_ACCESS) & i_psel & i_penable;
  assign wr_c       = xfer_c & i_pwrite & ~err_c;
  assign lnk_clr_c  = wr_c & (word_c == A_LNKDN);
  assign mask_we_c  = wr_c & (word_c == A_IRQ_MASK);
  assign busy_clr_c = busy_sel_c & {CH_NUM{wr_c}};
  assign w1c_c      = (wr_c && word_c == A_IRQ_STAT) ? i_pwdata[IRQ_W-1:0] : '0;

  // APB slave FSM; response is registered on the ACCESS->RESP edge
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      o_pready  <= 1'b0;
      o_pslverr <= 1'b0;
      o_prdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_psel && !i_penable) state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (!i_psel) begin
            state <= ST_IDLE;
          end else if (i_penable) begin
            state     <= ST_RESP;
            o_pready  <= 1'b1;
            o_pslverr <= err_c;
            o_prdata  <= (err_c || i_pwrite) ? '0 : rd_data_c;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          o_pready  <= 1'b0;
          o_pslverr <= 1'b0;
          o_prdata  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Monitor state: sync chain, captured BDF, interrupt and counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q    <= '0;
      lnk_d     <= 1'b0;
      busy_d    <= '0;
      bdf_q     <= '0;
      irq_stat  <= '0;
      irq_mask  <= '0;
      o_irq     <= 1'b0;
      lnkdn_cnt <= '0;
      for (int unsigned n = 0; n < CH_NUM; n++) busy_cnt[n] <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_lnk_up};
      lnk_d  <= lnk_s_c;
      busy_d <= i_dma_busy;
      if (i_cfg_valid) bdf_q <= i_cfg_bdf;
      // Hardware set wins over a same-cycle W1C
      irq_stat <= (irq_stat & ~w1c_c) | irq_set_c;
      if (mask_we_c) irq_mask <= i_pwdata[IRQ_W-1:0];
      o_irq <= |(irq_stat & irq_mask);
      if (lnk_clr_c) lnkdn_cnt <= '0;
      else if (lnk_fall_c && lnkdn_cnt != CNT_MAX) lnkdn_cnt <= lnkdn_cnt + CNT_WIDTH'(1);
      for (int unsigned n = 0; n < CH_NUM; n++) begin
        if (busy_clr_c[n]) busy_cnt[n] <= '0;
        else if (i_dma_busy[n] && busy_cnt[n] != CNT_MAX) busy_cnt[n] <= busy_cnt[n] + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: doc/apb_pcie_mon.md
APB_PCIE_MON -- requirements
Module: apb_pcie_mon

Interface
REQ-001 Parameter CH_NUM, default 4, number of DMA channels monitored (legal 1..8).
REQ-002 Parameter CNT_WIDTH, default 32, width of event/cycle counters (legal 8..32).
REQ-003 Parameter SYNC_STAGES, default 2, flop stages synchronising i_lnk_up (legal 2..4).
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_lnk_up  in  1  PCIe link-up, asynchronous to i_clk.
REQ-007 i_dma_busy  in  CH_NUM  per-channel DMA busy, synchronous to i_clk.
REQ-008 i_cfg_valid  in  1  strobe: BDF inputs valid this cycle.
REQ-009 i_cfg_bdf  in  16  [15:8] bus, [7:3] device, [2:0] function.
REQ-010 i_psel, i_penable, i_pwrite  in  1 each  APB control.
REQ-011 i_paddr  in  12  APB byte address; [1:0] ignored.
REQ-012 i_pwdata  in  32  APB write data.
REQ-013 o_prdata  out  32  APB read data, 0 when o_pready low.
REQ-014 o_pready  out  1  APB ready.
REQ-015 o_pslverr  out  1  APB error, valid only with o_pready.
REQ-016 o_irq  out  1  registered interrupt, level.

Function
REQ-017 APB FSM states IDLE, ACCESS, RESP: IDLE->ACCESS on i_psel&~i_penable; ACCESS->RESP on i_psel&i_penable; RESP->IDLE unconditionally; ACCESS with ~i_psel -> IDLE.
REQ-018 o_pready=1 exactly one cycle, in RESP (second cycle of access phase); o_prdata/o_pslverr registered on ACCESS->RESP.
REQ-019 Write side effects commit on the ACCESS->RESP edge, once per transfer.
REQ-020 Map: 0x00 STATUS RO {[8+CH_NUM-1:8] i_dma_busy, [0] lnk_up_s}; 0x04 BDF RO {[15:0] captured BDF}; 0x08 IRQ_STAT W1C; 0x0C IRQ_MASK RW; 0x10 LNKDN_CNT; 0x14 PARAM RO {[13:8] CNT_WIDTH, [3:0] CH_NUM}; 0x20+4*n BUSY_CNT[n], n<CH_NUM.
REQ-021 Unmapped address or write to RO register -> o_pslverr=1, o_prdata=0, no state change.
REQ-022 lnk_up_s = i_lnk_up after SYNC_STAGES flops; edges detected on lnk_up_s vs its delayed copy.
REQ-023 BDF register loads i_cfg_bdf on i_cfg_valid=1; holds otherwise.
REQ-024 LNKDN_CNT increments on lnk_up_s falling edge; saturates at 2^CNT_WIDTH-1; any write clears to 0.
REQ-025 BUSY_CNT[n] increments each cycle i_dma_busy[n]=1; saturates; any write clears to 0.
REQ-026 Counter clear and increment in same cycle -> counter = 0.
REQ-027 Counters zero-extended to 32 bits on read.
REQ-028 IRQ_STAT bits: [0] lnk_up_s rise, [1] lnk_up_s fall, [2+n] i_dma_busy[n] fall (channel done); bits above 2+CH_NUM-1 read 0.
REQ-029 Writing 1 clears an IRQ_STAT bit; hardware set in same cycle as W1C -> bit stays 1.
REQ-030 IRQ_MASK width 2+CH_NUM, unused bits read 0; o_irq registered = |(IRQ_STAT & IRQ_MASK), one cycle after the cause.

Reset
REQ-031 On i_rst=1, immediately: FSM IDLE, o_pready=0, o_pslverr=0, o_prdata=0, o_irq=0, sync chain 0, edge history 0, all registers and counters 0.
REQ-032 Reset during an APB transfer aborts it; no pready, no write commits; first transfer after release completes normally.
REQ-033 i_lnk_up already high at reset release -> one rise event after SYNC_STAGES+1 cycles (IRQ_STAT[0]=1).

Verification
REQ-034 Read PARAM with defaults -> o_pready in 2nd access cycle, o_prdata=0x0000_2004, o_pslverr=0.
REQ-035 i_lnk_up 0->1->0, mask=0x3 -> IRQ_STAT=0x3, o_irq=1, LNKDN_CNT=1; write 0x1 to 0x08 -> IRQ_STAT=0x2, o_irq stays 1; write 0x2 -> o_irq=0.
REQ-036 i_dma_busy[2] high 10 cycles then low -> BUSY_CNT[2]=10, IRQ_STAT[4]=1; write BUSY_CNT[2] while busy high -> reads 0 then resumes from 1.
REQ-037 CNT_WIDTH=8, busy held 300 cycles -> BUSY_CNT=0xFF, no wrap.
REQ-038 Write 0x00, read 0x18, read 0x20+4*CH_NUM -> o_pslverr=1 each, o_prdata=0, registers unchanged.
REQ-039 W1C of bit 1 in same cycle as link fall -> IRQ_STAT[1]=1; i_rst pulse mid-ACCESS -> o_pready never asserted, all reads 0 after release.
